// File: rtl/mcif_wr_cmpl_queue_pkg.sv
// Shared definitions for the MCIF write completion queue.
// Holds the thread count, the client thread ids and the descriptor field
// positions. Ingress, egress and the queue itself import this package.
package mcif_wr_cmpl_queue_pkg;

    localparam int MCIF_WR_THREAD_NUM = 5;
    localparam int CQ_TID_W           = 3;
    localparam int CQ_PD_W            = 3;

    // Client thread ids
    localparam logic [CQ_TID_W-1:0] BDMA = 3'd0;
    localparam logic [CQ_TID_W-1:0] SDP  = 3'd1;
    localparam logic [CQ_TID_W-1:0] PDP  = 3'd2;
    localparam logic [CQ_TID_W-1:0] CDP  = 3'd3;
    localparam logic [CQ_TID_W-1:0] RBK  = 3'd4;

    // Descriptor layout: {len[1:0], require_ack}
    localparam int CQ_ACK_BIT = 0;
    localparam int CQ_LEN_LSB = 1;
    localparam int CQ_LEN_MSB = 2;

    function automatic logic cq_tid_valid(input logic [CQ_TID_W-1:0] tid);
        return tid < CQ_TID_W'(MCIF_WR_THREAD_NUM);
    endfunction

endpackage

// File: rtl/mcif_wr_cmpl_queue_if.sv
// Push/pop bundle of the MCIF write completion queue.
// master : write ingress (push side) plus write egress (pop side)
// slave  : the completion queue
// Signals:
//   cq_wr_pvld/prdy/thread_id/pd : push one descriptor into a thread FIFO
//   cq_wr_err                    : sticky flag, push seen with thread_id >= 5
//   cq_rdN_pvld/prdy/pd          : head of thread N FIFO, N = 0..4
interface mcif_wr_cmpl_queue_if;
    import mcif_wr_cmpl_queue_pkg::*;

    logic                cq_wr_pvld;
    logic                cq_wr_prdy;
    logic [CQ_TID_W-1:0] cq_wr_thread_id;
    logic [CQ_PD_W-1:0]  cq_wr_pd;
    logic                cq_wr_err;

    logic                cq_rd0_pvld, cq_rd0_prdy;
    logic [CQ_PD_W-1:0]  cq_rd0_pd;
    logic                cq_rd1_pvld, cq_rd1_prdy;
    logic [CQ_PD_W-1:0]  cq_rd1_pd;
    logic                cq_rd2_pvld, cq_rd2_prdy;
    logic [CQ_PD_W-1:0]  cq_rd2_pd;
    logic                cq_rd3_pvld, cq_rd3_prdy;
    logic [CQ_PD_W-1:0]  cq_rd3_pd;
    logic                cq_rd4_pvld, cq_rd4_prdy;
    logic [CQ_PD_W-1:0]  cq_rd4_pd;

    modport master (
        output cq_wr_pvld, cq_wr_thread_id, cq_wr_pd,
        input  cq_wr_prdy, cq_wr_err,
        output cq_rd0_prdy, cq_rd1_prdy, cq_rd2_prdy, cq_rd3_prdy, cq_rd4_prdy,
        input  cq_rd0_pvld, cq_rd1_pvld, cq_rd2_pvld, cq_rd3_pvld, cq_rd4_pvld,
        input  cq_rd0_pd, cq_rd1_pd, cq_rd2_pd, cq_rd3_pd, cq_rd4_pd
    );

    modport slave (
        input  cq_wr_pvld, cq_wr_thread_id, cq_wr_pd,
        output cq_wr_prdy, cq_wr_err,
        input  cq_rd0_prdy, cq_rd1_prdy, cq_rd2_prdy, cq_rd3_prdy, cq_rd4_prdy,
        output cq_rd0_pvld, cq_rd1_pvld, cq_rd2_pvld, cq_rd3_pvld, cq_rd4_pvld,
        output cq_rd0_pd, cq_rd1_pd, cq_rd2_pd, cq_rd3_pd, cq_rd4_pd
    );

endinterface

// File: rtl/mcif_wr_cq_fifo.sv
// Single-thread synchronous FIFO used for each completion-queue thread.
// DEPTH must be a power of 2 (>= 2) so the pointers wrap naturally.
// Ports:
//   nvdla_core_clk, nvdla_core_rstn : clock, async active-low reset
//   push_vld/push_rdy/push_pd       : write side, push_rdy = not full
//   pop_vld/pop_rdy/pop_pd          : read side, pop_pd is the current head
// The head is read straight out of the flopped array, so a pushed entry
// becomes visible one cycle after the push; a full FIFO refuses a push even
// when a pop happens in the same cycle.
module mcif_wr_cq_fifo #(
    parameter int DEPTH = 8,
    parameter int PD_W  = 3
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rstn,
    input  logic            push_vld,
    output logic            push_rdy,
    input  logic [PD_W-1:0] push_pd,
    output logic            pop_vld,
    input  logic            pop_rdy,
    output logic [PD_W-1:0] pop_pd
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [PD_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push;
    logic            pop;

    assign push_rdy = (count != FULL_CNT);
    assign pop_vld  = (count != '0);
    assign push     = push_vld & push_rdy;
    assign pop      = pop_vld & pop_rdy;
    assign pop_pd   = mem[rd_ptr];

    // Storage is intentionally not reset; pop_pd is qualified by pop_vld.
    always_ff @(posedge nvdla_core_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_pd;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mcif_wr_cmpl_queue.sv
// MCIF write completion queue: one in-order FIFO per client thread.
// Ingress pushes a {len, require_ack} descriptor per issued write burst;
// egress pops the FIFO selected by bid on each B response.
// Ports:
//   nvdla_core_clk, nvdla_core_rstn : clock, async active-low reset
//   cq (slave)                      : push port, error flag and five read ports
// Pushes with thread_id >= 5 are accepted and dropped, and set cq_wr_err
// until reset so a mis-routed burst is never silently lost.
module mcif_wr_cmpl_queue
    import mcif_wr_cmpl_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    mcif_wr_cmpl_queue_if.slave   cq
);

    logic [MCIF_WR_THREAD_NUM-1:0] push_vld_v;
    logic [MCIF_WR_THREAD_NUM-1:0] push_rdy_v;
    logic [MCIF_WR_THREAD_NUM-1:0] pop_vld_v;
    logic [MCIF_WR_THREAD_NUM-1:0] pop_rdy_v;
    logic [CQ_PD_W-1:0]            pop_pd_v [MCIF_WR_THREAD_NUM];
    logic                          wr_prdy_mux;
    logic                          wr_err;

    for (genvar i = 0; i < MCIF_WR_THREAD_NUM; i++) begin : g_thread
        assign push_vld_v[i] = cq.cq_wr_pvld && (cq.cq_wr_thread_id == CQ_TID_W'(i));

        mcif_wr_cq_fifo #(
            .DEPTH (DEPTH),
            .PD_W  (CQ_PD_W)
        ) u_fifo (
            .nvdla_core_clk  (nvdla_core_clk),
            .nvdla_core_rstn (nvdla_core_rstn),
            .push_vld        (push_vld_v[i]),
            .push_rdy        (push_rdy_v[i]),
            .push_pd         (cq.cq_wr_pd),
            .pop_vld         (pop_vld_v[i]),
            .pop_rdy         (pop_rdy_v[i]),
            .pop_pd          (pop_pd_v[i])
        );
    end

    // Ready follows thread_id only; an unknown id is always accepted.
    always_comb begin
        wr_prdy_mux = 1'b1;
        for (int i = 0; i < MCIF_WR_THREAD_NUM; i++) begin
            if (cq.cq_wr_thread_id == CQ_TID_W'(i)) begin
                wr_prdy_mux = push_rdy_v[i];
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_err <= 1'b0;
        end else if (cq.cq_wr_pvld && !cq_tid_valid(cq.cq_wr_thread_id)) begin
            wr_err <= 1'b1;
        end
    end

    assign cq.cq_wr_prdy = wr_prdy_mux;
    assign cq.cq_wr_err  = wr_err;

    assign pop_rdy_v = {cq.cq_rd4_prdy, cq.cq_rd3_prdy, cq.cq_rd2_prdy,
                        cq.cq_rd1_prdy, cq.cq_rd0_prdy};

    assign cq.cq_rd0_pvld = pop_vld_v[0];
    assign cq.cq_rd1_pvld = pop_vld_v[1];
    assign cq.cq_rd2_pvld = pop_vld_v[2];
    assign cq.cq_rd3_pvld = pop_vld_v[3];
    assign cq.cq_rd4_pvld = pop_vld_v[4];

    assign cq.cq_rd0_pd = pop_pd_v[0];
    assign cq.cq_rd1_pd = pop_pd_v[1];
    assign cq.cq_rd2_pd = pop_pd_v[2];
    assign cq.cq_rd3_pd = pop_pd_v[3];
    assign cq.cq_rd4_pd = pop_pd_v[4];

endmodule

// File: doc/mcif_wr_cmpl_queue.md
Name: mcif_wr_cmpl_queue

Overview:
- Per-thread completion queue for the MCIF write path.
- The write ingress pushes one 3-bit descriptor per issued AXI write burst: {len[1:0], require_ack}.
- The write egress pops one entry per returned AXI B response, selected by bid, and uses it for ingress credit return and client completion pulses.
- The block holds 5 independent in-order FIFOs, one per client thread (0 bdma, 1 sdp, 2 pdp, 3 cdp, 4 rbk), and exposes each FIFO head on its own valid/ready read port.

Parameters:
- THREAD_NUM, 5, number of client threads and read ports. Fixed; ports are hand-enumerated.
- DEPTH, 8, entries per thread FIFO. Must be a power of 2, at least 2.
- PD_W, 3, descriptor width: bit0 require_ack, bits[2:1] len.

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  asynchronous active-low reset
- cq_wr_pvld  in  1  push request from ingress
- cq_wr_prdy  out  1  push accepted when high with pvld
- cq_wr_thread_id  in  3  target thread 0..4
- cq_wr_pd  in  3  descriptor {len, require_ack}
- cq_wr_err  out  1  sticky flag: push seen with thread_id >= 5
- cq_rd0_pvld  out  1  thread 0 FIFO non-empty
- cq_rd0_prdy  in  1  pop thread 0
- cq_rd0_pd  out  3  thread 0 head entry
- cq_rd1_pvld / cq_rd1_prdy / cq_rd1_pd  out/in/out  1/1/3  thread 1, same semantics
- cq_rd2_pvld / cq_rd2_prdy / cq_rd2_pd  out/in/out  1/1/3  thread 2
- cq_rd3_pvld / cq_rd3_prdy / cq_rd3_pd  out/in/out  1/1/3  thread 3
- cq_rd4_pvld / cq_rd4_prdy / cq_rd4_pd  out/in/out  1/1/3  thread 4

Behaviour:
- Clock and reset:
  - Clock nvdla_core_clk.
  - Reset nvdla_core_rstn is asynchronous and active-low.
  - All pointers, counters and cq_wr_err clear on reset.
  - Storage array is not reset.
- Reset values: all cq_rdN_pvld=0 and cq_wr_err=0. cq_rdN_pd is don't-care while pvld=0 and is driven from storage, so X is allowed in simulation.
- Per-FIFO state: wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- cq_wr_prdy is combinational: it is !full of the FIFO selected by cq_wr_thread_id, and 1 when thread_id >= 5.
  - prdy may toggle with thread_id.
  - prdy must not depend on cq_wr_pvld.
- Push (pvld & prdy, valid id):
  - mem[wr_ptr] <= pd, then wr_ptr++ and count++.
  - The entry is visible at cq_rdN_pd with pvld=1 on the next cycle. No same-cycle write-to-read bypass.
- Pop:
  - cq_rdN_pvld = (count != 0).
  - cq_rdN_pd = mem[rd_ptr], a zero-latency read of the flopped array.
  - A pop occurs when pvld & prdy. rd_ptr++ and count--.
  - prdy while empty is legal and ignored; the egress drives prdy independently of pvld, so this case is expected.
- Simultaneous push and pop on the same thread in one cycle:
  - count unchanged and both pointers advance.
  - When full: prdy=0, so the push is refused even if a pop occurs the same cycle (no full-bypass).
  - When count=1: pvld stays 1 and pd shows the new entry next cycle.
- Pops on different threads in the same cycle are independent. Any subset of the 5 may pop at once.
- Invalid thread_id (5..7) with pvld=1:
  - Push is consumed (prdy=1) and discarded.
  - No FIFO state changes.
  - cq_wr_err sets next cycle and holds until reset.
- Reset mid-operation: all queued entries are lost and every pvld drops asynchronously to 0. Upstream and downstream are reset by the same rstn.
- Descriptor is opaque: no arithmetic on pd, width passes through unchanged.

Decomposition:
- Shared package holds:
  - MCIF_WR_THREAD_NUM=5
  - thread id constants BDMA=0, SDP=1, PDP=2, CDP=3, RBK=4
  - CQ_PD_W=3
  - field positions: CQ_ACK_BIT=0, CQ_LEN_LSB=1, CQ_LEN_MSB=2
- One sub-module, mcif_wr_cq_fifo: a single-thread synchronous FIFO with parameters DEPTH and PD_W.
  - Ports: push vld/rdy/pd, pop vld/rdy/pd.
  - Instantiated 5 times.
- The top holds thread-id decode, the prdy mux and the error flag.

Test Plan:
- Push thread 2 pd=3'b101 after reset.
  - Next cycle: cq_rd2_pvld=1, cq_rd2_pd=101.
  - All other pvld stay 0.
  - Pop with cq_rd2_prdy=1 gives pvld=0 the following cycle.
- Push 8 entries to thread 0 with no pops.
  - cq_wr_prdy=0 for id 0, and 1 for id 1.
  - Push attempt with pop in the same cycle is refused.
  - After the pop, prdy=1 next cycle.
- Push values 0..7 then 0..3 to thread 4 with interleaved pops (12 total, pointers wrap).
  - Pop order matches push order exactly and count never exceeds 8.
- Thread 3 at count=1 (pd=010), push 111 and pop in the same cycle.
  - Next cycle: pvld=1, pd=111, count=1.
- Push with thread_id=5, pd=011.
  - prdy=1, all pvld unchanged.
  - cq_wr_err=1 next cycle and held for 20 cycles.
- With 3 entries in thread 1, pulse rstn low mid-cycle.
  - cq_rd1_pvld=0 immediately (asynchronous) and cq_wr_err=0.
  - After release, the queue is empty and accepts 8 pushes.
